writeback_queue: RTL and testbench
==================================

# writeback_queue

Write-side initiator for the core register file. Collects results from the ALU and load paths and buffers them in a small in-order FIFO. Issues them to the register file as `reg_wr` / `wr_rd` / `wr_data` beats, one per cycle, under the file's `rf_ready` flow control. Optionally answers operand-fetch lookups with the youngest pending value for a source register.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `XLEN`, 32: data width.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ld_valid`  in  1  load result valid.
- `ld_ready`  out  1  load result accepted when `ld_valid & ld_ready`.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  XLEN  load result.
- `alu_valid`  in  1  ALU result valid.
- `alu_ready`  out  1  ALU handshake.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `reg_wr`  out  1  write request to the register file.
- `wr_rd`  out  5  write address.
- `wr_data`  out  XLEN  write data.
- `rf_ready`  in  1  register file accepts the beat this cycle.
- `pending_cnt`  out  $clog2(DEPTH)+1  occupied entries.
- `rs1`, `rs2`  in  5 each  lookup addresses (`WBQ_BYPASS_EN` only).
- `byp1_hit`, `byp2_hit`  out  1 each  pending match found (`WBQ_BYPASS_EN` only).
- `byp1_data`, `byp2_data`  out  XLEN each  youngest matching data (`WBQ_BYPASS_EN` only).

## Operation
- Circular buffer: `rd_ptr`, `wr_ptr`, `count`. Each entry holds `{rd[4:0], data[XLEN-1:0]}`.
- Readiness uses registered `count` only. A pop in the same cycle does not free space.
  - `ld_ready = (count ≤ DEPTH-1)`.
  - `alu_ready = ld_valid ? (count ≤ DEPTH-2) : (count ≤ DEPTH-1)`.
- Up to two pushes per cycle. Load is written first (older), ALU second; `wr_ptr` advances by the number of entries actually written.
- Writes to x0 (`rd==0`) complete the handshake but are discarded and not enqueued.
- Head presentation: `reg_wr = (count != 0)`, with `wr_rd` and `wr_data` taken from the head entry.
  - When `count == 0`, `wr_rd` and `wr_data` are 0.
- Pop on `reg_wr & rf_ready`. While `rf_ready` is low, the head stays stable.
- Count arithmetic: `count_next = count + pushes - pop`, range 0..DEPTH. Pointers wrap modulo DEPTH.

## Timing
- Reset, asynchronous: pointers and `count` go to 0, and all entries are cleared.
  - Resulting output values: `reg_wr=0`, `wr_rd=0`, `wr_data=0`, `pending_cnt=0`, bypass hits 0.
  - `ld_ready` and `alu_ready` are 0 while `reset` is high. They rise in the first cycle after deassertion.
- Reset mid-operation drops all pending entries. No partial beat is retained.
- Latency: a result accepted in cycle N into an empty queue drives `reg_wr=1` in cycle N+1. Throughput is 1 write/cycle.
- Simultaneous load and ALU accept to the same `rd`: both are enqueued, load then ALU. The ALU value therefore lands last in the file.
- Full (`count==DEPTH`): both readies are low. A pop that cycle does not raise ready until the next cycle.
- Push into an empty queue and pop never occur on the same entry in one cycle. The pushed entry is first visible next cycle.

## Configuration
- `WBQ_BYPASS_EN` defined: `rs1`/`rs2` and the bypass outputs exist.
  - The lookup combinationally scans all occupied entries.
  - `bypN_hit=1` when any entry's `rd` equals `rsN` and `rsN != 0`.
  - `bypN_data` is the youngest matching entry's data, otherwise 0.
  - Entries enqueued in the current cycle are not visible to the lookup.
- Not defined: the bypass ports and the search logic are absent, and the queue is write-only.

## Test plan
- Reset release, then `ld_valid=1`, `ld_rd=5`, `ld_data=32'hDEADBEEF` for one cycle:
  - next cycle, `reg_wr=1`, `wr_rd=5`, `wr_data=DEADBEEF`;
  - with `rf_ready=1`, `pending_cnt` returns to 0.
- `rf_ready=0`, push 4 ALU results to x1..x4:
  - `pending_cnt=4`, both readies are 0, and the head stays x1;
  - then `rf_ready=1`: writes x1, x2, x3, x4 in order on 4 consecutive cycles.
- Same cycle, load `rd=7` data 1 and ALU `rd=7` data 2:
  - two beats, data 1 then data 2;
  - with bypass, `rs1=7` gives `byp1_hit=1`, `byp1_data=2` while both are pending.
- ALU write with `rd=0`, data FFFFFFFF: `alu_ready` handshake completes, `pending_cnt` stays 0, and `reg_wr` stays 0.
- Queue holding 3 entries, assert `reset` asynchronously mid-cycle:
  - `reg_wr`, `pending_cnt` and the readies drop immediately;
  - after release, the queue is empty and accepts a new write.
- `count=3`, `DEPTH=4`, both sources valid: `ld_ready=1`, `alu_ready=0`; only the load is enqueued and `count` becomes 4.

Source files
------------

// File: rtl/writeback_queue_if.sv
// writeback_queue_if: groups the load/ALU result handshakes, the register-file
// write beat, the occupancy count and, when WBQ_BYPASS_EN is defined, the
// operand-fetch lookup ports of writeback_queue.
// The master modport is the queue side and the slave modport is the
// surrounding core and register file.
interface writeback_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // load result path
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;

  // ALU result path
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  // register file write beat
  logic            reg_wr;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;
  logic            rf_ready;

  // occupancy
  logic [CNT_W-1:0] pending_cnt;

`ifdef WBQ_BYPASS_EN
  // operand-fetch lookup
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            byp1_hit;
  logic            byp2_hit;
  logic [XLEN-1:0] byp1_data;
  logic [XLEN-1:0] byp2_data;
`endif

  modport master (
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    output reg_wr, wr_rd, wr_data,
    input  rf_ready,
    output pending_cnt
`ifdef WBQ_BYPASS_EN
    ,
    input  rs1, rs2,
    output byp1_hit, byp2_hit, byp1_data, byp2_data
`endif
  );

  modport slave (
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    input  reg_wr, wr_rd, wr_data,
    output rf_ready,
    input  pending_cnt
`ifdef WBQ_BYPASS_EN
    ,
    output rs1, rs2,
    input  byp1_hit, byp2_hit, byp1_data, byp2_data
`endif
  );

endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back FIFO between the ALU/load result
// paths and the register file. Up to two results are accepted per cycle
// (load older than ALU), writes to x0 are swallowed, and the head entry is
// offered to the register file as a reg_wr beat under rf_ready.
// Optional feature macro: WBQ_BYPASS_EN adds the rs1/rs2 lookup that returns
// the youngest pending value for a source register.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic clock,
  input  logic reset,
  writeback_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // pointer / occupancy state
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // entry storage, flattened out of the per-entry generate blocks
  logic [4:0]      entry_rd   [DEPTH];
  logic [XLEN-1:0] entry_data [DEPTH];

  // handshake and push/pop decode
  logic             ld_fire, alu_fire;
  logic             ld_push, alu_push;
  logic [1:0]       num_push;
  logic [PTR_W-1:0] alu_slot;
  logic             head_valid;
  logic             pop;

  // Readiness looks only at the registered count, so a pop in the same
  // cycle never frees space; the ALU must leave room for a concurrent load.
  assign bus.ld_ready  = !reset && (count_reg <= CNT_W'(DEPTH - 1));
  assign bus.alu_ready = !reset && (bus.ld_valid ? (count_reg <= CNT_W'(DEPTH - 2))
                                                 : (count_reg <= CNT_W'(DEPTH - 1)));

  assign ld_fire  = bus.ld_valid  && bus.ld_ready;
  assign alu_fire = bus.alu_valid && bus.alu_ready;
  // x0 writes complete the handshake but never occupy an entry
  assign ld_push  = ld_fire  && (bus.ld_rd  != 5'd0);
  assign alu_push = alu_fire && (bus.alu_rd != 5'd0);
  assign num_push = {1'b0, ld_push} + {1'b0, alu_push};
  // the ALU result lands just behind the load when both are enqueued
  assign alu_slot = wr_ptr_reg + PTR_W'(ld_push);

  assign head_valid = (count_reg != '0);
  assign pop        = head_valid && bus.rf_ready;

  // Per-entry storage: each slot captures the load or the ALU result when
  // the write pointer (or the slot behind it) selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] data_reg;
    logic            ld_we;
    logic            alu_we;

    assign ld_we  = ld_push  && (wr_ptr_reg == PTR_W'(gi));
    assign alu_we = alu_push && (alu_slot   == PTR_W'(gi));

    // capture an incoming result into this slot; reset empties it
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rd_reg   <= '0;
        data_reg <= '0;
      end else if (ld_we) begin
        rd_reg   <= bus.ld_rd;
        data_reg <= bus.ld_data;
      end else if (alu_we) begin
        rd_reg   <= bus.alu_rd;
        data_reg <= bus.alu_data;
      end
    end

    assign entry_rd[gi]   = rd_reg;
    assign entry_data[gi] = data_reg;
  end

  // next pointers and count from this cycle's pushes and pop
  always_comb begin
    wr_ptr_next = wr_ptr_reg + PTR_W'(num_push);
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    count_next  = count_reg + CNT_W'(num_push) - CNT_W'(pop);
  end

  // pointer and count registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // present the head entry as the write beat; zeros while empty
  always_comb begin
    bus.reg_wr  = head_valid;
    bus.wr_rd   = '0;
    bus.wr_data = '0;
    if (head_valid) begin
      bus.wr_rd   = entry_rd[rd_ptr_reg];
      bus.wr_data = entry_data[rd_ptr_reg];
    end
  end

  assign bus.pending_cnt = count_reg;

`ifdef WBQ_BYPASS_EN
  // Walk occupied entries oldest to youngest so the last match wins; only
  // registered entries are searched, so this cycle's pushes are invisible.
  function automatic logic [XLEN:0] lookup(input logic [4:0] rs);
    logic [XLEN:0]    result;
    logic [PTR_W-1:0] idx;
    result = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_reg + PTR_W'(i);
      if ((CNT_W'(i) < count_reg) && (rs != 5'd0) && (entry_rd[idx] == rs)) begin
        result = {1'b1, entry_data[idx]};
      end
    end
    return result;
  endfunction

  // answer both operand lookups from the pending entries
  always_comb begin
    {bus.byp1_hit, bus.byp1_data} = lookup(bus.rs1);
    {bus.byp2_hit, bus.byp2_data} = lookup(bus.rs2);
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed stimulus for writeback_queue with a
// scoreboard of expected register-file beats checked by a separate monitor.
// Bypass checks are compiled in when WBQ_BYPASS_EN is defined.
module tb_writeback_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  writeback_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q [$];
  logic [36:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = 5'd0;
    bus.ld_data   = '0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = '0;
  endtask

  // monitor: every beat the register file accepts is compared in order
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && bus.reg_wr && bus.rf_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got rd %0d data %h expected no beat", bus.wr_rd, bus.wr_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("beat", 64'({bus.wr_rd, bus.wr_data}), 64'(mon_exp));
        end
      end
    end
  end

  initial begin
    idle();
    bus.rf_ready = 1'b1;
`ifdef WBQ_BYPASS_EN
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
`endif
    tick();
    tick();

    // reset state while reset is held
    check("rst_reg_wr",    64'(bus.reg_wr),      64'd0);
    check("rst_wr_rd",     64'(bus.wr_rd),       64'd0);
    check("rst_wr_data",   64'(bus.wr_data),     64'd0);
    check("rst_pending",   64'(bus.pending_cnt), 64'd0);
    check("rst_ld_ready",  64'(bus.ld_ready),    64'd0);
    check("rst_alu_ready", 64'(bus.alu_ready),   64'd0);

    // single load, one-cycle latency, immediate drain
    reset = 1'b0;
    #1;
    check("rel_ld_ready",  64'(bus.ld_ready),  64'd1);
    check("rel_alu_ready", 64'(bus.alu_ready), 64'd1);
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 5'd5;
    bus.ld_data  = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    idle();
    check("t1_reg_wr",  64'(bus.reg_wr),      64'd1);
    check("t1_wr_rd",   64'(bus.wr_rd),       64'd5);
    check("t1_wr_data", 64'(bus.wr_data),     64'hDEADBEEF);
    check("t1_pending", 64'(bus.pending_cnt), 64'd1);
    tick();
    check("t1_drained", 64'(bus.pending_cnt), 64'd0);

    // fill with rf_ready low, head must hold, then drain in order
    bus.rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(i);
      bus.alu_data  = 32'h1000_0000 + 32'(i);
      exp_q.push_back({5'(i), 32'h1000_0000 + 32'(i)});
      tick();
    end
    idle();
    #1;
    check("t2_pending",   64'(bus.pending_cnt), 64'd4);
    check("t2_ld_ready",  64'(bus.ld_ready),    64'd0);
    check("t2_alu_ready", 64'(bus.alu_ready),   64'd0);
    check("t2_head",      64'(bus.wr_rd),       64'd1);
    tick();
    tick();
    check("t2_head_stable", 64'(bus.wr_rd),   64'd1);
    check("t2_data_stable", 64'(bus.wr_data), 64'h1000_0001);
    bus.rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t2_drained", 64'(bus.pending_cnt), 64'd0);

    // load and ALU to the same rd in one cycle: load first, ALU last
    bus.rf_ready  = 1'b0;
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd7;
    bus.ld_data   = 32'd1;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 32'd2;
    exp_q.push_back({5'd7, 32'd1});
    exp_q.push_back({5'd7, 32'd2});
    tick();
    idle();
    check("t3_pending", 64'(bus.pending_cnt), 64'd2);
`ifdef WBQ_BYPASS_EN
    bus.rs1 = 5'd7;
    bus.rs2 = 5'd5;
    #1;
    check("t3_byp1_hit",  64'(bus.byp1_hit),  64'd1);
    check("t3_byp1_data", 64'(bus.byp1_data), 64'd2);
    check("t3_byp2_hit",  64'(bus.byp2_hit),  64'd0);
    check("t3_byp2_data", 64'(bus.byp2_data), 64'd0);
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
`endif
    bus.rf_ready = 1'b1;
    tick();
    tick();
    check("t3_drained", 64'(bus.pending_cnt), 64'd0);

    // write to x0 handshakes but is discarded
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'hFFFFFFFF;
    #1;
    check("t4_alu_ready", 64'(bus.alu_ready), 64'd1);
    tick();
    idle();
    check("t4_pending", 64'(bus.pending_cnt), 64'd0);
    check("t4_reg_wr",  64'(bus.reg_wr),      64'd0);
    tick();
    check("t4_reg_wr_later", 64'(bus.reg_wr), 64'd0);

    // asynchronous reset with three entries pending
    bus.rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'(10 + i);
      bus.ld_data  = 32'hA000 + 32'(i);
      tick();
    end
    idle();
    check("t5_pending", 64'(bus.pending_cnt), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_reg_wr",    64'(bus.reg_wr),      64'd0);
    check("t5_rst_pending",   64'(bus.pending_cnt), 64'd0);
    check("t5_rst_ld_ready",  64'(bus.ld_ready),    64'd0);
    check("t5_rst_alu_ready", 64'(bus.alu_ready),   64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("t5_rel_pending",  64'(bus.pending_cnt), 64'd0);
    check("t5_rel_reg_wr",   64'(bus.reg_wr),      64'd0);
    check("t5_rel_ld_ready", 64'(bus.ld_ready),    64'd1);
    bus.rf_ready = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 5'd9;
    bus.ld_data  = 32'd99;
    exp_q.push_back({5'd9, 32'd99});
    tick();
    idle();
    check("t5_new_reg_wr", 64'(bus.reg_wr), 64'd1);
    check("t5_new_wr_rd",  64'(bus.wr_rd),  64'd9);
    tick();
    check("t5_drained", 64'(bus.pending_cnt), 64'd0);

    // count=3 with both sources valid: only the load fits
    bus.rf_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(i);
      bus.alu_data  = 32'h30 + 32'(i);
      exp_q.push_back({5'(i), 32'h30 + 32'(i)});
      tick();
    end
    idle();
    check("t6_pending3", 64'(bus.pending_cnt), 64'd3);
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd20;
    bus.ld_data   = 32'hAA;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd21;
    bus.alu_data  = 32'hBB;
    #1;
    check("t6_ld_ready",  64'(bus.ld_ready),  64'd1);
    check("t6_alu_ready", 64'(bus.alu_ready), 64'd0);
    exp_q.push_back({5'd20, 32'hAA});
    tick();
    idle();
    check("t6_pending4",   64'(bus.pending_cnt), 64'd4);
    check("t6_full_ready", 64'(bus.ld_ready),    64'd0);
    bus.rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t6_drained", 64'(bus.pending_cnt), 64'd0);
    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
